// File: rtl/i2c_mm_arbiter.sv
// Round-robin Avalon-MM arbiter sharing one I2C master register port.
// Lock keeps the grant across multi-register sequences; idle timeout frees it.
module i2c_mm_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ*ADDR_W-1:0]   req_address,
    input  logic [NREQ-1:0]          req_read,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*DATA_W-1:0]   req_writedata,
    input  logic [NREQ-1:0]          req_lock,
    output logic [NREQ-1:0]          req_waitrequest,
    output logic [DATA_W-1:0]        req_readdata,
    output logic [NREQ-1:0]          req_readdatavalid,
    output logic [ADDR_W-1:0]        m_address,
    output logic                     m_read,
    output logic                     m_write,
    output logic [DATA_W-1:0]        m_writedata,
    input  logic                     m_waitrequest,
    input  logic [DATA_W-1:0]        m_readdata,
    input  logic                     m_readdatavalid,
    output logic [NREQ-1:0]          grant,
    output logic                     lock_timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, HOLD} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   g, g_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0] pending;
    logic [IW-1:0]   pick;
    logic            g_rd, g_wr, g_lock, g_strobe, timeout_hit;

    assign pending     = req_read | req_write;
    assign g_rd        = req_read[g];
    assign g_wr        = req_write[g];
    assign g_lock      = req_lock[g];
    assign g_strobe    = g_rd | g_wr;
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // Owner fields and read data are routed straight through.
    assign m_address    = req_address[int'(g)*ADDR_W +: ADDR_W];
    assign m_writedata  = req_writedata[int'(g)*DATA_W +: DATA_W];
    assign req_readdata = m_readdata;

    // Round-robin pick: first pending requester after the last owner.
    always_comb begin
        int          idx;
        logic [IW-1:0] idx_w;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx   = (int'(last) + k) % NREQ;
            idx_w = IW'(idx);
            if (pending[idx_w]) pick = idx_w;
        end
    end

    // State, owner, last owner and idle counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            g     <= '0;
            last  <= IW'(NREQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; counter only runs while idling in HOLD.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last;
        cnt_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    g_nxt     = pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!g_strobe) begin
                    state_nxt = IDLE;
                    last_nxt  = g;
                end else if (!m_waitrequest) begin
                    if (g_rd) begin
                        state_nxt = WAIT_RD;
                    end else if (g_lock) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                        last_nxt  = g;
                    end
                end
            end
            WAIT_RD: begin
                if (m_readdatavalid) begin
                    if (g_lock) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                        last_nxt  = g;
                    end
                end
            end
            HOLD: begin
                if (g_strobe) begin
                    state_nxt = ISSUE;
                end else if (!g_lock || timeout_hit) begin
                    state_nxt = IDLE;
                    last_nxt  = g;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    // Outputs: only the owner sees its waitrequest and valid strobe.
    always_comb begin
        grant             = '0;
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        m_read            = 1'b0;
        m_write           = 1'b0;
        lock_timeout      = 1'b0;
        unique case (state)
            IDLE: ;
            ISSUE: begin
                grant[g]           = 1'b1;
                m_read             = g_rd;
                m_write            = g_wr;
                req_waitrequest[g] = m_waitrequest;
            end
            WAIT_RD: begin
                grant[g]             = 1'b1;
                req_readdatavalid[g] = m_readdatavalid;
            end
            HOLD: begin
                grant[g]     = 1'b1;
                lock_timeout = !g_strobe && g_lock && timeout_hit;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_mm_arbiter.sv
// Directed bench for i2c_mm_arbiter: read, fairness, lock,
// timeout, strobe/timeout collision and reset mid-read.
module tb_i2c_mm_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 3;
    localparam int DW   = 32;

    logic              clk;
    logic              reset;
    logic [NREQ*AW-1:0] req_address;
    logic [NREQ-1:0]   req_read;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*DW-1:0] req_writedata;
    logic [NREQ-1:0]   req_lock;
    logic [NREQ-1:0]   req_waitrequest;
    logic [DW-1:0]     req_readdata;
    logic [NREQ-1:0]   req_readdatavalid;
    logic [AW-1:0]     m_address;
    logic              m_read;
    logic              m_write;
    logic [DW-1:0]     m_writedata;
    logic              m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic              m_readdatavalid;
    logic [NREQ-1:0]   grant;
    logic              lock_timeout;

    int n_cmp = 0;
    int n_err = 0;

    i2c_mm_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_address(req_address),
        .req_read(req_read),
        .req_write(req_write),
        .req_writedata(req_writedata),
        .req_lock(req_lock),
        .req_waitrequest(req_waitrequest),
        .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .m_address(m_address),
        .m_read(m_read),
        .m_write(m_write),
        .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .grant(grant),
        .lock_timeout(lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        req_address     = '0;
        req_read        = '0;
        req_write       = '0;
        req_writedata   = '0;
        req_lock        = '0;
        m_waitrequest   = 1'b0;
        m_readdata      = '0;
        m_readdatavalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_grant", grant, 0);
        check("rst_wait", req_waitrequest, 3'b111);
        check("rst_rdv", req_readdatavalid, 0);
        check("rst_mrd", m_read, 0);
        check("rst_mwr", m_write, 0);
        check("rst_to", lock_timeout, 0);

        // Single read by requester 1
        req_address[1*AW +: AW] = 3'd4;
        req_read[1]   = 1'b1;
        m_waitrequest = 1'b1;
        #1;
        check("rd_idle_grant", grant, 0);
        tick(); #1;
        check("rd_grant", grant, 3'b010);
        check("rd_mread", m_read, 1);
        check("rd_addr", m_address, 4);
        check("rd_stall0", req_waitrequest, 3'b111);
        tick(); #1;
        check("rd_stall1", req_waitrequest, 3'b111);
        tick();
        m_waitrequest = 1'b0;
        #1;
        check("rd_accept", req_waitrequest, 3'b101);
        tick();
        req_read = '0;
        #1;
        check("rd_wait_mread", m_read, 0);
        check("rd_wait_grant", grant, 3'b010);
        tick();
        tick();
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hA5;
        #1;
        check("rd_valid", req_readdatavalid, 3'b010);
        check("rd_data", req_readdata, 32'hA5);
        tick();
        m_readdatavalid = 1'b0;
        #1;
        check("rd_done_grant", grant, 0);
        check("rd_done_rdv", req_readdatavalid, 0);

        // Fairness: all three write continuously
        do_reset();
        req_address[0*AW +: AW] = 3'd1;
        req_address[1*AW +: AW] = 3'd2;
        req_address[2*AW +: AW] = 3'd3;
        req_write = 3'b111;
        for (int i = 0; i < 12; i++) begin
            logic [2:0] eg;
            eg = (i % 2 == 1) ? 3'(1 << ((i / 2) % 3)) : 3'b000;
            #1;
            check($sformatf("rr_grant%0d", i), grant, eg);
            check($sformatf("rr_mwr%0d", i), m_write, i % 2);
            if (i % 2 == 1)
                check($sformatf("rr_addr%0d", i), m_address,
                      ((i / 2) % 3) + 1);
            tick();
        end
        req_write = '0;
        tick();
        tick();

        // Lock: requester 2 runs TXR, CR, 5x SR while 0 waits
        do_reset();
        req_lock[2]  = 1'b1;
        req_write[2] = 1'b1;
        req_address[2*AW +: AW] = 3'd3;
        tick(); #1;
        check("lk_txr_grant", grant, 3'b100);
        check("lk_txr_addr", m_address, 3);
        tick();
        req_write[2] = 1'b0;
        req_write[0] = 1'b1;
        #1;
        check("lk_hold_grant", grant, 3'b100);
        check("lk_hold_wait0", req_waitrequest[0], 1);
        req_write[2] = 1'b1;
        req_address[2*AW +: AW] = 3'd4;
        tick(); #1;
        check("lk_cr_wr", m_write, 1);
        check("lk_cr_addr", m_address, 4);
        tick();
        req_write[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_read[2] = 1'b1;
            req_address[2*AW +: AW] = 3'd4;
            tick(); #1;
            check($sformatf("lk_sr_grant%0d", i), grant, 3'b100);
            check($sformatf("lk_sr_rd%0d", i), m_read, 1);
            tick();
            req_read[2]     = 1'b0;
            m_readdatavalid = 1'b1;
            m_readdata      = 32'(i + 8'h80);
            #1;
            check($sformatf("lk_sr_rdv%0d", i), req_readdatavalid, 3'b100);
            tick();
            m_readdatavalid = 1'b0;
        end
        req_lock[2] = 1'b0;
        #1;
        check("lk_drop_grant", grant, 3'b100);
        tick(); #1;
        check("lk_idle_grant", grant, 0);
        tick(); #1;
        check("lk_r0_grant", grant, 3'b001);
        check("lk_r0_wr", m_write, 1);
        tick();
        req_write = '0;
        tick();

        // Timeout: requester 1 locks and stalls, 2 pending
        do_reset();
        req_lock[1]  = 1'b1;
        req_write[1] = 1'b1;
        req_address[1*AW +: AW] = 3'd5;
        tick(); #1;
        check("to_acc_grant", grant, 3'b010);
        tick();
        req_write[1] = 1'b0;
        req_write[2] = 1'b1;
        for (int k = 1; k < 16; k++) begin
            #1;
            check($sformatf("to_quiet%0d", k), lock_timeout, 0);
            tick();
        end
        #1;
        check("to_pulse", lock_timeout, 1);
        check("to_pulse_grant", grant, 3'b010);
        tick(); #1;
        check("to_after", lock_timeout, 0);
        check("to_idle_grant", grant, 0);
        tick(); #1;
        check("to_r2_grant", grant, 3'b100);
        tick();
        req_write = '0;
        req_lock  = '0;
        tick();

        // Strobe on the exact timeout cycle wins
        do_reset();
        req_lock[1]  = 1'b1;
        req_write[1] = 1'b1;
        tick();
        tick();
        req_write[1] = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        req_write[1] = 1'b1;
        #1;
        check("col_no_pulse", lock_timeout, 0);
        tick(); #1;
        check("col_issue_grant", grant, 3'b010);
        check("col_issue_wr", m_write, 1);
        req_lock[1] = 1'b0;
        tick();
        req_write = '0;
        #1;
        check("col_idle_grant", grant, 0);

        // Reset in WAIT_RD discards the late readdatavalid
        do_reset();
        req_read[0] = 1'b1;
        req_address[0*AW +: AW] = 3'd2;
        tick();
        tick();
        req_read = '0;
        #1;
        check("rr_wait_grant", grant, 3'b001);
        reset = 1'b1;
        tick();
        m_readdatavalid = 1'b1;
        #1;
        check("mr_rdv", req_readdatavalid, 0);
        check("mr_grant", grant, 0);
        check("mr_wait", req_waitrequest, 3'b111);
        check("mr_mrd", m_read, 0);
        reset = 1'b0;
        tick(); #1;
        check("mr_rdv_post", req_readdatavalid, 0);
        check("mr_grant_post", grant, 0);
        m_readdatavalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
